// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//
// Decoupling queue between fetch and decode. It holds {pc, instruction}
// pairs in arrival order and presents the oldest one to decode through a
// valid/ready handshake. Fetch can keep filling the queue while decode is
// frozen. A branch flush drops every queued entry.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous reset, active low
//   flush            synchronous clear of all entries (branch taken)
//   in_valid         fetch offers an entry
//   in_ready         queue has room (depends on registered count only)
//   in_pc            pc from fetch
//   in_instruction   instruction word from fetch
//   out_valid        head entry is valid
//   out_ready        decode takes the head this cycle
//   out_pc           head pc; zero when out_valid is low
//   out_instruction  head instruction; zero when out_valid is low (NOP)
//   count            number of occupied entries
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [WIDTH-1:0]           in_instruction,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_pc,
    output logic [WIDTH-1:0]           out_instruction,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_pc    [DEPTH];
    logic [WIDTH-1:0] mem_instr [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             wr_en;
    logic             rd_en;

    // Full/empty come only from the registered count, so out_ready never
    // reaches in_ready combinationally and a full queue refuses a write
    // even while the head is being consumed.
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // Flush overrides both handshakes.
    assign wr_en = in_valid && in_ready && !flush;
    assign rd_en = out_valid && out_ready && !flush;

    // Decode sees a NOP (all zeros) whenever the queue is empty.
    assign out_pc          = out_valid ? mem_pc[rd_ptr]    : '0;
    assign out_instruction = out_valid ? mem_instr[rd_ptr] : '0;

    // Storage carries no reset; contents are only observed when valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr]    <= in_pc;
            mem_instr[wr_ptr] <= in_instruction;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_instruction;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_instruction;
    logic [2:0]       count;

    if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_instruction  (in_instruction),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic [31:0] pc;
        logic        out_ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [2:0]  exp_count;
        logic        exp_ready;
        string       tag;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;

    function automatic logic [31:0] ins_of(logic [31:0] pc);
        if (pc == 32'h4) return 32'hE3A01005;
        return 32'hE000_0000 | pc;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(string tag, logic fl, logic iv, logic [31:0] pc, logic ordy,
                       logic ev, logic [31:0] epc, logic [2:0] ecnt, logic erdy);
        vec_t v;
        v.tag = tag; v.flush = fl; v.in_valid = iv; v.pc = pc; v.out_ready = ordy;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_count = ecnt; v.exp_ready = erdy;
        vecs.push_back(v);
    endtask

    task automatic chk_state(string tag, logic ev, logic [31:0] epc, logic [2:0] ecnt, logic erdy);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".out_pc"}, out_pc, ev ? epc : 32'h0);
        chk({tag, ".out_instr"}, out_instruction, ev ? ins_of(epc) : 32'h0);
        chk({tag, ".count"}, 32'(count), 32'(ecnt));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(erdy));
    endtask

    task automatic drive(logic fl, logic iv, logic [31:0] pc, logic ordy);
        flush          = fl;
        in_valid       = iv;
        in_pc          = pc;
        in_instruction = ins_of(pc);
        out_ready      = ordy;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // tag, flush, in_valid, pc, out_ready -> valid, head pc, count, in_ready
        add("t1_write",     0, 1, 32'h04, 0, 1, 32'h04, 3'd1, 1);
        add("t2_fill2",     0, 1, 32'h08, 0, 1, 32'h04, 3'd2, 1);
        add("t2_fill3",     0, 1, 32'h0C, 0, 1, 32'h04, 3'd3, 1);
        add("t2_fill4",     0, 1, 32'h10, 0, 1, 32'h04, 3'd4, 0);
        add("t2_reject",    0, 1, 32'h14, 0, 1, 32'h04, 3'd4, 0);
        add("t3_full_rd",   0, 1, 32'h14, 1, 1, 32'h08, 3'd3, 1);
        add("t3_wrap_wr",   0, 1, 32'h14, 1, 1, 32'h0C, 3'd3, 1);
        add("t3_wr18",      0, 1, 32'h18, 1, 1, 32'h10, 3'd3, 1);
        add("t3_drain1",    0, 0, 32'h00, 1, 1, 32'h14, 3'd2, 1);
        add("t3_drain2",    0, 0, 32'h00, 1, 1, 32'h18, 3'd1, 1);
        add("t3_empty",     0, 0, 32'h00, 1, 0, 32'h00, 3'd0, 1);
        add("t3_underflow", 0, 0, 32'h00, 1, 0, 32'h00, 3'd0, 1);
        add("t4_nobypass",  0, 1, 32'h20, 1, 1, 32'h20, 3'd1, 1);
        add("t4_cnt2",      0, 1, 32'h24, 0, 1, 32'h20, 3'd2, 1);
        add("t4_both1",     0, 1, 32'h28, 1, 1, 32'h24, 3'd2, 1);
        add("t4_both2",     0, 1, 32'h2C, 1, 1, 32'h28, 3'd2, 1);
        add("t4_both3",     0, 1, 32'h30, 1, 1, 32'h2C, 3'd2, 1);
        add("t5_cnt3",      0, 1, 32'h34, 0, 1, 32'h2C, 3'd3, 1);
        add("t5_flush",     1, 1, 32'h40, 1, 0, 32'h00, 3'd0, 1);
        add("t5_idle",      0, 0, 32'h00, 0, 0, 32'h00, 3'd0, 1);
        add("t5_wr44",      0, 1, 32'h44, 0, 1, 32'h44, 3'd1, 1);
        add("t5_wr48",      0, 1, 32'h48, 0, 1, 32'h44, 3'd2, 1);

        rst = 1'b0;
        drive(0, 0, 32'h0, 0);
        #1;
        chk_state("reset_now", 0, 32'h0, 3'd0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset_held", 0, 32'h0, 3'd0, 1);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].flush, vecs[i].in_valid, vecs[i].pc, vecs[i].out_ready);
            @(posedge clk);
            #1;
            chk_state(vecs[i].tag, vecs[i].exp_valid, vecs[i].exp_pc,
                      vecs[i].exp_count, vecs[i].exp_ready);
        end

        // Asynchronous reset mid-stream with two entries queued.
        drive(0, 0, 32'h0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_state("t6_async", 0, 32'h0, 3'd0, 1);
        @(posedge clk);
        #1;
        chk_state("t6_held", 0, 32'h0, 3'd0, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_state("t6_released", 0, 32'h0, 3'd0, 1);
        drive(0, 1, 32'h50, 0);
        @(posedge clk);
        #1;
        chk_state("t6_first", 1, 32'h50, 3'd1, 1);
        drive(0, 0, 32'h0, 1);
        @(posedge clk);
        #1;
        chk_state("t6_alone", 0, 32'h0, 3'd0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling instruction queue between the fetch stage and the decode stage.
- Captures {pc, instruction} pairs from fetch and presents them in order to decode with a valid/ready handshake.
- Lets fetch keep running while decode is frozen (hazard stall).
- Discards all queued entries on a branch flush so no wrong-path instruction reaches decode.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- WIDTH, 32, width of the pc field and of the instruction field.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush (branch taken); empties the queue.
- in_valid  input  1  fetch presents a valid entry.
- in_ready  output  1  queue can accept an entry this cycle.
- in_pc  input  WIDTH  pc value from fetch (already incremented by 4).
- in_instruction  input  WIDTH  fetched instruction word.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head this cycle (driven as not-freeze).
- out_pc  output  WIDTH  pc of the head entry.
- out_instruction  output  WIDTH  instruction of the head entry.
- count  output  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst low, asynchronous):
  - write pointer, read pointer and count go to 0.
  - out_valid = 0; out_pc = 0; out_instruction = 0; in_ready = 1.
  - Storage contents are don't-care.
  - Reset may assert mid-operation; queue is empty on the first edge after release.
- Enqueue handshake: an entry is written when in_valid && in_ready at the rising edge.
  - Write lands at the write pointer; pointer increments modulo DEPTH.
- Dequeue handshake: the head retires when out_valid && out_ready at the rising edge.
  - Read pointer increments modulo DEPTH.
- in_ready = (count != DEPTH).
  - Purely registered-state based: no combinational path from out_ready to in_ready.
  - A full queue rejects a write even if a dequeue happens in the same cycle.
- out_valid = (count != 0).
  - First-word-fall-through: an entry written at edge N is visible on out_* during the cycle after edge N.
  - Latency from in to out is 1 cycle when empty.
- out_pc and out_instruction show the head entry when out_valid = 1, and are forced to 0 when out_valid = 0 (decode sees a NOP).
- Simultaneous enqueue and dequeue on a non-empty, non-full queue: both pointers advance and count is unchanged.
- Enqueue to an empty queue with out_ready high: no same-cycle bypass. The entry appears on the next cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty is decided by count only.
- count: incremented on enqueue only, decremented on dequeue only, unchanged when both or neither occur. Never exceeds DEPTH and never underflows.
- flush has priority over everything:
  - At the edge where flush = 1, pointers and count go to 0.
  - A simultaneous enqueue is discarded.
  - A simultaneous dequeue has no effect beyond the clear.
  - out_valid = 0 in the cycle after the flush.
  - in_ready is unaffected by flush in the flush cycle itself; the discarded write does not count.
- Out-of-range states are unreachable. No error outputs.

Test Plan:
1. Reset then single write:
   - Stimulus: rst low 2 cycles, release; in_valid=1, in_pc=0x4, in_instruction=0xE3A01005 for one cycle, out_ready=0.
   - Required response: next cycle out_valid=1, out_pc=0x4, out_instruction=0xE3A01005, count=1.
2. Fill to full with decode frozen:
   - Stimulus: write pcs 0x4, 0x8, 0xC, 0x10 back to back, out_ready=0.
   - Required response: after the 4th write count=4 and in_ready=0. A 5th write of pc 0x14 is ignored; out_pc stays 0x4.
3. Drain in order with wrap:
   - Stimulus: from full, out_ready=1 while writing pcs 0x14, 0x18 as space frees.
   - Required response: out_pc sequence is 0x4, 0x8, 0xC, 0x10, 0x14, 0x18. Pointers wrap past entry 3, and out_* = 0 once count returns to 0.
4. Concurrent enqueue and dequeue:
   - Stimulus: count=2, in_valid=1 and out_ready=1 for 3 cycles.
   - Required response: count stays 2 each cycle and output order is preserved.
5. Flush with a simultaneous write:
   - Stimulus: count=3, flush=1 and in_valid=1 with pc 0x40 in the same cycle.
   - Required response: next cycle count=0, out_valid=0, out_pc=0. pc 0x40 never appears on the output.
6. Asynchronous reset mid-stream:
   - Stimulus: count=2, rst driven low between clock edges.
   - Required response: out_valid=0, count=0 and in_ready=1 immediately without a clock edge. After release, the first new write appears alone at the head.
